// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the EXE-stage multiply/divide unit.
//   - MD_WIDTH   : default datapath width, shared with the ALU and register file
//   - MD_MUL_LAT : default multiply latency (issue edge to result edge)
//   - md_op_e    : op encodings driven on the unit's 3-bit op port
//   - md_state_e : control FSM state encoding
//   - md_is_signed() : true for the two signed ops (MULT, DIV)
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_MUL_LAT = 4;

  // Codes 6 and 7 are reserved and are ignored by the unit.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_divcore.sv
// -----------------------------------------------------------------------------
// muldiv_divcore
//   Iterative radix-2 restoring divider working on unsigned magnitudes.
//   One quotient bit is produced per clock; WIDTH iterations per divide.
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-low reset
//     start      in   load operands and begin a divide (ignores any run)
//     abort      in   stop the current divide; wins over start
//     dividend   in   WIDTH  unsigned dividend magnitude
//     divisor    in   WIDTH  unsigned divisor magnitude
//     done       out  high during the final iteration cycle; quotient and
//                     remainder hold the final values from the next cycle on
//     quotient   out  WIDTH  quotient register
//     remainder  out  WIDTH  remainder register
//
//   A zero divisor is not special-cased here: the loop simply yields an
//   all-ones quotient. The caller overrides the result for that case.
// -----------------------------------------------------------------------------
module muldiv_divcore
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  // Partial remainder with the next dividend bit shifted in, and the trial
  // subtraction. The extra top bit of trial is the borrow (negative result).
  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign trial   = partial - {1'b0, dvs_q};

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;

    if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(WIDTH);
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (run_q) begin
      // Restore on borrow: keep the shifted remainder, quotient bit 0.
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      rem_d = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d = 1'b0;
      end
    end

    if (abort) begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign done      = run_q && (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide unit for the EXE stage. Owns HI/LO.
//   MULT/MULTU: full 2*WIDTH product, written MUL_LAT edges after issue.
//   DIV/DIVU  : restoring divide plus a sign-fix cycle, written WIDTH+1
//               edges after issue.
//   MTHI/MTLO : written at the issue edge.
//
//   Ports
//     clk     in   rising-edge clock
//     rst     in   asynchronous active-low reset
//     start   in   issue strobe, only taken while busy=0
//     op      in   3  operation code (md_op_e); 6 and 7 are ignored
//     a       in   WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
//     b       in   WIDTH  rt operand (divisor / multiplier)
//     cancel  in   flush: drops any in-flight op and any same-cycle issue
//     busy    out  high while the FSM is not idle
//     done    out  one-cycle pulse as hi/lo take a mul/div result
//     hi, lo  out  WIDTH  architectural HI and LO registers
//     div0    out  sticky divide-by-zero flag, cleared by the next issue
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = MD_WIDTH,
  parameter int MUL_LAT = MD_MUL_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int PW = 2 * WIDTH;

  // ---------------------------------------------------------------------------
  // Issue decode
  // ---------------------------------------------------------------------------
  md_state_e state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;

  logic idle, accept;
  logic is_mul, is_div, is_mthi, is_mtlo, sgn;

  assign idle    = (state_q == ST_IDLE);
  assign accept  = start && idle && !cancel && (op <= 3'd5);
  assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div  = (op == MD_DIV)  || (op == MD_DIVU);
  assign is_mthi = (op == MD_MTHI);
  assign is_mtlo = (op == MD_MTLO);
  assign sgn     = md_is_signed(op);

  // ---------------------------------------------------------------------------
  // Multiplier: product of the extended operands, then a MUL_LAT-deep delay.
  // Sign- or zero-extending both operands to 2*WIDTH makes the low 2*WIDTH
  // bits of a plain product correct for both MULT and MULTU.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] a_ext, b_ext, product;

  assign a_ext   = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign b_ext   = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;

  logic [PW-1:0]      mpipe_q [MUL_LAT];
  logic [PW-1:0]      mpipe_d [MUL_LAT];
  logic [MUL_LAT-1:0] mvld_q, mvld_d;
  // Per-entry write enables for the two halves. A later MTHI/MTLO clears
  // them so an older product cannot overwrite a younger register write.
  logic [MUL_LAT-1:0] mhi_en_q, mhi_en_d;
  logic [MUL_LAT-1:0] mlo_en_q, mlo_en_d;

  always_comb begin
    for (int i = 0; i < MUL_LAT; i++) begin
      mpipe_d[i] = mpipe_q[i];
    end
    mvld_d   = '0;
    mhi_en_d = '0;
    mlo_en_d = '0;

    mpipe_d[0]  = product;
    mvld_d[0]   = accept && is_mul;
    mhi_en_d[0] = 1'b1;
    mlo_en_d[0] = 1'b1;
    for (int i = 1; i < MUL_LAT; i++) begin
      mpipe_d[i]  = mpipe_q[i-1];
      mvld_d[i]   = mvld_q[i-1];
      mhi_en_d[i] = mhi_en_q[i-1];
      mlo_en_d[i] = mlo_en_q[i-1];
    end

    if (accept && is_mthi) begin
      mhi_en_d = '0;
    end
    if (accept && is_mtlo) begin
      mlo_en_d = '0;
    end
    if (cancel) begin
      mvld_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider: magnitudes into the core, signs kept here for the FIX cycle.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo, rem;
  logic             div_last;

  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  muldiv_divcore #(
    .WIDTH (WIDTH)
  ) u_divcore (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div),
    .abort     (cancel),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_last),
    .quotient  (quo),
    .remainder (rem)
  );

  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dzero_q, dzero_d;
  logic [WIDTH-1:0] dsave_q, dsave_d;

  always_comb begin
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dzero_d = dzero_q;
    dsave_d = dsave_q;
    if (accept && is_div) begin
      // Quotient sign is the XOR of operand signs; remainder follows the
      // dividend. MIN / -1 needs no special case: the magnitude quotient is
      // 2^(WIDTH-1), which already reads back as the most-negative value.
      qneg_d  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d  = sgn && a[WIDTH-1];
      dzero_d = (b == '0);
      dsave_d = a;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // With MUL_LAT=1 the product lands one edge after issue through the
        // delay line alone, so the FSM never leaves IDLE.
        if (accept && is_mul && (MUL_LAT > 1)) begin
          state_d = ST_MUL;
          mcnt_d  = 4'(MUL_LAT - 2);
        end else if (accept && is_div) begin
          state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        if (mcnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end
      ST_DIV: begin
        if (div_last) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cancel) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO, done and div0 update
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic             mul_wr, div_wr;

  // A cancel in the completion cycle suppresses the write.
  assign mul_wr = mvld_q[MUL_LAT-1] && !cancel;
  assign div_wr = (state_q == ST_FIX) && !cancel;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    div0_d = div0_q;

    if (accept) begin
      div0_d = 1'b0;
    end

    if (mul_wr) begin
      done_d = 1'b1;
      if (mhi_en_q[MUL_LAT-1]) begin
        hi_d = mpipe_q[MUL_LAT-1][PW-1:WIDTH];
      end
      if (mlo_en_q[MUL_LAT-1]) begin
        lo_d = mpipe_q[MUL_LAT-1][WIDTH-1:0];
      end
    end

    if (div_wr) begin
      done_d = 1'b1;
      if (dzero_q) begin
        lo_d   = '1;
        hi_d   = dsave_q;
        div0_d = 1'b1;
      end else begin
        lo_d = qneg_q ? -quo : quo;
        hi_d = rneg_q ? -rem : rem;
      end
    end

    // Register moves are younger than any product still in the delay line,
    // so they take priority at a coinciding edge.
    if (accept && is_mthi) begin
      hi_d = a;
    end
    if (accept && is_mtlo) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mcnt_q   <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        mpipe_q[i] <= '0;
      end
      mvld_q   <= '0;
      mhi_en_q <= '0;
      mlo_en_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dzero_q  <= 1'b0;
      dsave_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        mpipe_q[i] <= mpipe_d[i];
      end
      mvld_q   <= mvld_d;
      mhi_en_q <= mhi_en_d;
      mlo_en_q <= mlo_en_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dzero_q  <= dzero_d;
      dsave_q  <= dsave_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Drives muldiv_unit (WIDTH=32, MUL_LAT=4) with directed cases and random
//   traffic. A reference model keeps HI/LO, div0 and a list of pending
//   result writes (due edge, values); every negedge the DUT outputs are
//   compared against it.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo),
    .div0   (div0)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] h;
    logic [31:0] l;
    bit          wh;
    bit          wl;
    bit          z;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] hi_m = '0, lo_m = '0;
  logic        done_m = 1'b0, div0_m = 1'b0, busy_m = 1'b0;
  int          cyc = 0;
  int          busy_end = 0;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    pend.delete();
    hi_m = '0; lo_m = '0; done_m = 1'b0; div0_m = 1'b0; busy_m = 1'b0;
    busy_end = 0;
  endtask

  // Advance the model across one rising edge with the given inputs applied.
  task automatic model_step(input logic s, input logic [2:0] o,
                            input logic [31:0] aa, input logic [31:0] bb, input logic c);
    int          e;
    bit          idle;
    pend_t       keep[$];
    pend_t       n;
    longint      sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int          ia, ib;
    e = cyc + 1;
    idle = (cyc >= busy_end);
    done_m = 1'b0;
    if (c) begin
      pend.delete();
      busy_end = 0;
    end else begin
      keep = {};
      foreach (pend[i]) begin
        if (pend[i].due == e) begin
          done_m = 1'b1;
          if (pend[i].wh) hi_m = pend[i].h;
          if (pend[i].wl) lo_m = pend[i].l;
          if (pend[i].z) div0_m = 1'b1;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
      if (s && idle && o <= 3'd5) begin
        div0_m = 1'b0;
        n.wh = 1'b1; n.wl = 1'b1; n.z = 1'b0;
        case (o)
          3'd0, 3'd1: begin
            if (o == 3'd0) begin
              sa = longint'($signed(aa)); sb = longint'($signed(bb));
              p = 64'(sa * sb);
            end else begin
              ua = 64'(aa); ub = 64'(bb);
              p = ua * ub;
            end
            n.due = e + L; n.h = p[63:32]; n.l = p[31:0];
            pend.push_back(n);
            busy_end = e + L - 1;
          end
          3'd2, 3'd3: begin
            if (bb == 32'd0) begin
              n.l = 32'hFFFF_FFFF; n.h = aa; n.z = 1'b1;
            end else if (o == 3'd2) begin
              if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                n.l = 32'h8000_0000; n.h = 32'd0;
              end else begin
                ia = $signed(aa); ib = $signed(bb);
                n.l = 32'(ia / ib); n.h = 32'(ia % ib);
              end
            end else begin
              n.l = aa / bb; n.h = aa % bb;
            end
            n.due = e + W + 1;
            pend.push_back(n);
            busy_end = e + W + 1;
          end
          3'd4: begin
            hi_m = aa;
            foreach (pend[i]) pend[i].wh = 1'b0;
          end
          default: begin
            lo_m = aa;
            foreach (pend[i]) pend[i].wl = 1'b0;
          end
        endcase
      end
    end
    cyc = e;
    busy_m = (cyc < busy_end);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("hi", hi, hi_m);
      check("lo", lo, lo_m);
      check("busy", 32'(busy), 32'(busy_m));
      check("done", 32'(done), 32'(done_m));
      check("div0", 32'(div0), 32'(div0_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic tick(input logic s, input logic [2:0] o,
                      input logic [31:0] aa, input logic [31:0] bb, input logic c);
    start = s; op = o; a = aa; b = bb; cancel = c;
    @(posedge clk);
    #1;
    model_step(s, o, aa, bb, c);
    @(negedge clk);
  endtask

  task automatic idle_tick();
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    tick(1'b1, o, aa, bb, 1'b0);
    if (busy) bcnt++;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      idle_tick();
      if (busy) bcnt++;
      if (done) lat = n;
    end
    if (lat < 0) check("run_op_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, dn;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_div0", 32'(div0), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle_tick();

    // MULT -3 * 7
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    check("mult_latency", 32'(lat), 32'd4);
    check("mult_busy_cycles", 32'(bcnt), 32'd3);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    idle_tick();
    check("mult_done_pulse_width", 32'(done), 32'd0);

    // MULTU max * max
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    check("div_latency", 32'(lat), 32'd33);
    check("div_busy_cycles", 32'(bcnt), 32'd33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 7
    run_op(3'd3, 32'd100, 32'd7, lat, bcnt);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // Divide by zero, then MIN / -1
    run_op(3'd2, 32'd5, 32'd0, lat, bcnt);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd5);
    check("div0_flag", 32'(div0), 32'd1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);
    check("divovf_flag_cleared", 32'(div0), 32'd0);

    // MTHI while idle
    tick(1'b1, 3'd4, 32'h0000_1234, 32'd0, 1'b0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_no_done", 32'(done), 32'd0);
    check("mthi_no_busy", 32'(busy), 32'd0);

    // MTLO while a DIV is in flight is ignored
    tick(1'b1, 3'd2, 32'd1000, 32'd10, 1'b0);
    idle_tick();
    idle_tick();
    tick(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    check("mtlo_busy_lo", lo, 32'h8000_0000);
    check("mtlo_busy_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 40 && busy; n++) idle_tick();
    check("div_after_mtlo_lo", lo, 32'd100);
    check("div_after_mtlo_hi", hi, 32'd0);

    // Cancel a DIV at its 10th cycle
    tick(1'b1, 3'd2, 32'd77, 32'd5, 1'b0);
    repeat (9) idle_tick();
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check("cancel_busy_drop", 32'(busy), 32'd0);
    dn = 0;
    repeat (40) begin idle_tick(); if (done) dn++; end
    check("cancel_no_done", 32'(dn), 32'd0);
    check("cancel_hi_kept", hi, 32'd0);
    check("cancel_lo_kept", lo, 32'd100);

    // Cancel and start in the same idle cycle
    tick(1'b1, 3'd0, 32'd3, 32'd3, 1'b1);
    check("cancel_start_busy", 32'(busy), 32'd0);
    dn = 0;
    repeat (6) begin idle_tick(); if (done) dn++; end
    check("cancel_start_no_done", 32'(dn), 32'd0);

    // Cancel in the MULT completion cycle
    tick(1'b1, 3'd0, 32'd5, 32'd5, 1'b0);
    repeat (3) idle_tick();
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check("cancel_final_no_done", 32'(done), 32'd0);
    check("cancel_final_lo", lo, 32'd100);

    // Asynchronous reset in the middle of a MULT
    tick(1'b1, 3'd4, 32'h0000_0055, 32'd0, 1'b0);
    tick(1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
    idle_tick();
    #2 rst = 1'b0;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) idle_tick();

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      tick(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), pick(), pick(),
           ($urandom_range(0, 40) == 0));
    end
    repeat (40) idle_tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
